muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the Execute stage. The Execute stage raises `start` for an M-extension instruction and holds it while `stallRequest` freezes the pipeline. The unit runs a pipelined multiply or an iterative radix-2^k divide, then presents the result for exactly one cycle on `done`. It also generalises the ALU with configurable width, multiply latency and divide throughput, plus flush-abort behaviour.

## Interface
- `XLEN`, 32: operand/result width.
- `MUL_LATENCY`, 2: cycles spent in MUL state (>=1).
- `DIV_BITS_PER_CYCLE`, 1: quotient bits retired per DIV cycle; must divide `XLEN` (1, 2 or 4).
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level request from Execute; valid, non-illegal M-op in the decode/execute payload.
- `flush`  in  1  Execute/Memory flush; aborts any operation.
- `op`  in  mdOp_  MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU.
- `operand1`  in  XLEN  rs1 after forwarding.
- `operand2`  in  XLEN  rs2 after forwarding.
- `busy`  out  1  state is MUL, DIV or FIX.
- `stallRequest`  out  1  `start && state != DONE && !flush`.
- `done`  out  1  state == DONE; one-cycle pulse.
- `result`  out  XLEN  final value; registered; held until the next accept or reset.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **Accept:** IDLE && `start` && !`flush`. Latch `op` and both operands. Later changes on the inputs are ignored.
- **Accept routing:**
  - Multiply ops -> MUL.
  - Divide by zero, or signed overflow (DIV/REM with operand1 = 0x8000_0000, operand2 = 0xFFFF_FFFF) -> DONE directly, with the special result.
  - All other divides -> DIV, with count = `XLEN/DIV_BITS_PER_CYCLE`.
- **MUL:** holds for `MUL_LATENCY` cycles, then -> DONE. Product is 2*`XLEN` bits:
  - Operands are sign- or zero-extended to `XLEN`+1 bits per op (MULHSU: rs1 signed, rs2 unsigned).
  - MUL returns the low half; the MULH* ops return the high half.
- **DIV:** restoring division on magnitudes. Each cycle retires `DIV_BITS_PER_CYCLE` quotient bits and decrements count. At count 0 -> FIX.
- **FIX:** one cycle of sign correction, then -> DONE.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
- **DONE:** `result` valid and `done`=1. Always -> IDLE next cycle. `start` is ignored in DONE, because the same instruction still drives it.
- **Special results:**
  - Divide by zero: DIV/DIVU return 0xFFFF_FFFF; REM/REMU return operand1.
  - Signed overflow: DIV returns 0x8000_0000; REM returns 0.
- **Flush:** any state -> IDLE at the next edge. `done` is suppressed in the flush cycle; `result` is not updated.
  - Flush and `start` in the same cycle: flush wins, nothing is accepted.
- **Reset:** state IDLE, `result`=0, count=0. Consequently `busy`=0, `done`=0, `stallRequest` follows `start`.
  - Reset mid-operation discards all work.

## Timing
- Accept at cycle 0 (edge at the end of cycle 0). `done` is high in:
  - multiply: cycle `MUL_LATENCY`+1;
  - normal divide: cycle `XLEN/DIV_BITS_PER_CYCLE`+2 (34 for defaults);
  - special divide: cycle 1.
- `stallRequest` is high from cycle 0 through the cycle before DONE. It is low in the DONE cycle, so the pipeline advances and captures `result` that same cycle.
- Minimum spacing between accepts: DONE cycle plus one IDLE cycle. A back-to-back M-op in the next instruction is accepted in the cycle after DONE.
- `result` and state are registered. `busy`, `done` and `stallRequest` are combinational from state and inputs only; there is no path from the operands.

## Structure
- Add to `pack`:
  - `mdOp_` enum;
  - `mdState_` enum;
  - a `decodeExecutePayload_` field carrying `mdOp_` plus an `isMulDiv` flag.
- Sub-module `muldiv_divider`: iterative magnitude divider (remainder/quotient registers, count, k-bit step). It is started by a `muldiv_unit` strobe and reports `divDone`.
- Multiply stays in the top level as a `MUL_LATENCY`-deep registered product pipe.

## Test plan
- MULH 0xFFFF_FFFF × 0xFFFF_FFFF; MULHU same operands; MULHSU 0xFFFF_FFFF × 2 -> 0x0000_0000, 0xFFFF_FFFE, 0xFFFF_FFFF. Each `done` in cycle 3 (defaults).
- DIV −7 / 2 -> −3 (0xFFFF_FFFD); REM −7 / 2 -> −1. `done` in cycle 34. `stallRequest` is high in cycles 0–33 and low in 34.
- DIVU 100 / 0 -> 0xFFFF_FFFF; REMU 100 / 0 -> 100; DIV 0x8000_0000 / −1 -> 0x8000_0000. Each `done` in cycle 1.
- Flush asserted in cycle 10 of a DIV -> IDLE in cycle 11, no `done` pulse, `result` unchanged. Flush with `start` in the same IDLE cycle -> no accept.
- `start` held through DONE -> no re-accept. Drop, then reassert with new operands -> accepted in the next IDLE cycle.
- `DIV_BITS_PER_CYCLE`=4: DIVU 0xFFFF_FFFF / 3 -> 0x5555_5555, `done` in cycle 10. Reset asserted in cycle 5 -> `result`=0, IDLE.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: op codes, FSM states and
// the decode/execute payload fields that steer it.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } mdOp_;

   typedef enum logic [2:0] {
      ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE
   } mdState_;

   typedef struct packed {
      mdOp_ mdOp;
      logic isMulDiv;
   } decodeExecutePayload_;

   // Divide-family ops occupy the upper half of the encoding.
   function automatic logic is_div_op(input mdOp_ o);
      return o[2];
   endfunction

   function automatic logic is_signed_div(input mdOp_ o);
      return (o == MD_DIV) || (o == MD_REM);
   endfunction

   function automatic logic is_rem_op(input mdOp_ o);
      return (o == MD_REM) || (o == MD_REMU);
   endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring divider on unsigned magnitudes; retires
// DIV_BITS_PER_CYCLE quotient bits per step.
module muldiv_divider #(
   parameter int XLEN               = 32,
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            divStart,
   input  logic            divStep,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            divDone,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int STEPS = XLEN / DIV_BITS_PER_CYCLE;
   localparam int CW    = $clog2(STEPS + 1);

   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN:0]   part;
   logic [XLEN-1:0] qw;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      count_d = count_q;
      part    = {1'b0, rem_q};
      qw      = quo_q;
      if (divStart) begin
         rem_d   = '0;
         quo_d   = dividend;
         dvs_d   = divisor;
         count_d = CW'(STEPS);
      end else if (divStep && (count_q != '0)) begin
         // Shift one dividend bit into the partial remainder per sub-step;
         // the extra top bit keeps the compare exact for full-width divisors.
         for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            part = {part[XLEN-1:0], qw[XLEN-1]};
            qw   = {qw[XLEN-2:0], 1'b0};
            if (part >= {1'b0, dvs_q}) begin
               part  = part - {1'b0, dvs_q};
               qw[0] = 1'b1;
            end
         end
         rem_d   = part[XLEN-1:0];
         quo_d   = qw;
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         count_q <= '0;
      end else begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         count_q <= count_d;
      end
   end

   // High during the step that retires the final quotient bits.
   assign divDone   = divStep && (count_q == CW'(1));
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit beside the Execute-stage ALU:
// pipelined multiply, iterative divide, one-cycle done pulse.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN               = 32,
   parameter int MUL_LATENCY        = 2,
   parameter int DIV_BITS_PER_CYCLE = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  mdOp_            op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            busy,
   output logic            stallRequest,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int MCW = $clog2(MUL_LATENCY + 1);

   mdState_          state_q, state_d;
   mdOp_             op_q, op_d;
   logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
   logic [XLEN-1:0]  result_q, result_d;

   logic                   accept, div_zero, div_ovf, sgn, a_neg, b_neg;
   logic [XLEN-1:0]        mag_a, mag_b, special_res, quo, rem;
   logic                   div_start, div_done;
   logic signed [XLEN:0]   ext1, ext2;
   logic signed [2*XLEN-1:0] prod_d;
   logic [2*XLEN-1:0]      prod_q [MUL_LATENCY];
   logic [2*XLEN-1:0]      prod_out;

   assign accept   = (state_q == ST_IDLE) && start && !flush;
   assign div_zero = (operand2 == '0);
   assign div_ovf  = is_signed_div(op) && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                     && (operand2 == '1);
   assign sgn      = is_signed_div(op);
   assign a_neg    = sgn && operand1[XLEN-1];
   assign b_neg    = sgn && operand2[XLEN-1];
   assign mag_a    = a_neg ? (~operand1 + 1'b1) : operand1;
   assign mag_b    = b_neg ? (~operand2 + 1'b1) : operand2;
   assign div_start = accept && is_div_op(op) && !div_zero && !div_ovf;

   always_comb begin
      special_res = operand1;
      if (div_zero) special_res = is_rem_op(op) ? operand1 : '1;
      else          special_res = is_rem_op(op) ? '0 : operand1;
   end

   // Free-running product pipe: stage N holds the product of the operands
   // presented N+1 cycles ago, so the accept-cycle product exits on time.
   assign ext1   = {((op == MD_MULH) || (op == MD_MULHSU)) && operand1[XLEN-1], operand1};
   assign ext2   = {(op == MD_MULH) && operand2[XLEN-1], operand2};
   assign prod_d = ext1 * ext2;

   always_ff @(posedge clock) begin
      prod_q[0] <= prod_d;
      for (int i = 1; i < MUL_LATENCY; i++) prod_q[i] <= prod_q[i-1];
   end
   assign prod_out = prod_q[MUL_LATENCY-1];

   muldiv_divider #(.XLEN(XLEN), .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)) u_div (
      .clock    (clock),
      .reset    (reset),
      .divStart (div_start),
      .divStep  (state_q == ST_DIV),
      .dividend (mag_a),
      .divisor  (mag_b),
      .divDone  (div_done),
      .quotient (quo),
      .remainder(rem)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      mul_cnt_d = mul_cnt_q;
      result_d  = result_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               op_d      = op;
               a_neg_d   = a_neg;
               b_neg_d   = b_neg;
               mul_cnt_d = '0;
               if (!is_div_op(op))          state_d = ST_MUL;
               else if (div_zero || div_ovf) begin
                  state_d  = ST_DONE;
                  result_d = special_res;
               end else                     state_d = ST_DIV;
            end
            ST_MUL: begin
               mul_cnt_d = mul_cnt_q + MCW'(1);
               if (mul_cnt_q == MCW'(MUL_LATENCY - 1)) begin
                  state_d  = ST_DONE;
                  result_d = (op_q == MD_MUL) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];
               end
            end
            ST_DIV: if (div_done) state_d = ST_FIX;
            ST_FIX: begin
               state_d = ST_DONE;
               if (is_rem_op(op_q)) result_d = a_neg_q ? (~rem + 1'b1) : rem;
               else                 result_d = (a_neg_q ^ b_neg_q) ? (~quo + 1'b1) : quo;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= MD_MUL;
         a_neg_q   <= 1'b0;
         b_neg_q   <= 1'b0;
         mul_cnt_q <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_neg_q   <= a_neg_d;
         b_neg_q   <= b_neg_d;
         mul_cnt_q <= mul_cnt_d;
         result_q  <= result_d;
      end
   end

   assign busy         = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
   assign done         = (state_q == ST_DONE) && !flush;
   assign stallRequest = start && (state_q != ST_DONE) && !flush;
   assign result       = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected result/done-cycle, monitors pop
// on each done pulse of the default unit and of a 4-bit-per-cycle divider.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, start, flush, busy, stallRequest, done;
   mdOp_        op;
   logic [31:0] operand1, operand2, result;
   logic        reset4, start4, flush4, busy4, stall4, done4;
   mdOp_        op4;
   logic [31:0] a4, b4, result4;

   muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS_PER_CYCLE(1)) dut (
      .clock(clock), .reset(reset), .start(start), .flush(flush), .op(op),
      .operand1(operand1), .operand2(operand2), .busy(busy),
      .stallRequest(stallRequest), .done(done), .result(result));

   muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS_PER_CYCLE(4)) dut4 (
      .clock(clock), .reset(reset4), .start(start4), .flush(flush4), .op(op4),
      .operand1(a4), .operand2(b4), .busy(busy4),
      .stallRequest(stall4), .done(done4), .result(result4));

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   exp_t        q[$], q4[$];
   int          cyc = 0;
   int          n_vec = 0, n_err = 0;
   logic [31:0] last_res;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitors sample mid-cycle, after stimulus changes at the falling edge.
   always @(negedge clock) begin
      exp_t e;
      #2;
      if (done) begin
         if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      #2;
      if (done4) begin
         if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
         else begin
            e = q4.pop_front();
            chk("result4", result4, e.res);
            chk("done_cycle4", cyc, e.cyc);
         end
      end
   end

   // Presents an op and holds start through its DONE cycle, as Execute does.
   task automatic run_op(input mdOp_ o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat);
      exp_t x;
      @(negedge clock);
      op = o; operand1 = a; operand2 = b; start = 1'b1;
      x.res = e; x.cyc = cyc + lat;
      q.push_back(x);
      for (int k = 0; k <= lat; k++) begin
         if (k > 0) @(negedge clock);
         #1;
         if (k == 0 || k >= lat - 1) chk("stall", stallRequest, (k < lat) ? 32'd1 : 32'd0);
      end
      last_res = e;
   endtask

   task automatic idle();
      @(negedge clock);
      start = 1'b0;
      #1 chk("idle_busy", busy, 32'd0);
   endtask

   task automatic run4(input mdOp_ o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat);
      exp_t x;
      @(negedge clock);
      op4 = o; a4 = a; b4 = b; start4 = 1'b1;
      x.res = e; x.cyc = cyc + lat;
      q4.push_back(x);
      repeat (lat) @(negedge clock);
      #1 chk("stall4_done", stall4, 32'd0);
      @(negedge clock);
      start4 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; flush = 1'b0; op = MD_MUL; operand1 = '0; operand2 = '0;
      reset4 = 1'b1; start4 = 1'b0; flush4 = 1'b0; op4 = MD_MUL; a4 = '0; b4 = '0;
      last_res = '0;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_result", result, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_done", done, 32'd0);
      chk("rst_stall_follows_start", stallRequest, 32'd1);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0; reset4 = 1'b0;

      // multiplies: done in cycle 3
      run_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3); idle();
      run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3); idle();
      run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 3); idle();
      run_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 3); idle();

      // normal divides: done in cycle 34
      run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34); idle();
      run_op(MD_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34); idle();
      run_op(MD_DIVU, 32'd100,       32'd7,         32'd14,        34); idle();
      run_op(MD_REMU, 32'd100,       32'd7,         32'd2,         34); idle();
      run_op(MD_DIV,  32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 34); idle();
      run_op(MD_REM,  32'd20,        32'hFFFF_FFFA, 32'd2,         34); idle();

      // special divides: done in cycle 1
      run_op(MD_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1); idle();
      run_op(MD_REMU, 32'd100,       32'd0,         32'd100,       1); idle();
      run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); idle();
      run_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1); idle();
      run_op(MD_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1); idle();

      // start held through DONE, new op accepted in the cycle after DONE
      run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
      run_op(MD_DIVU,  32'd100,       32'd7,         32'd14,        34);
      run_op(MD_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
      run_op(MD_REMU,  32'd9,         32'd0,         32'd9,         1); idle();

      // flush in cycle 10 of a divide
      @(negedge clock);
      op = MD_DIV; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
      repeat (10) @(negedge clock);
      flush = 1'b1;
      #1 chk("flush_stall", stallRequest, 32'd0);
      chk("flush_busy_before", busy, 32'd1);
      @(negedge clock);
      flush = 1'b0; start = 1'b0;
      #1 chk("flush_idle", busy, 32'd0);
      chk("flush_result_kept", result, last_res);
      repeat (40) @(negedge clock);

      // flush and start together in IDLE
      @(negedge clock);
      op = MD_DIVU; operand1 = 32'd9; operand2 = 32'd3; start = 1'b1; flush = 1'b1;
      #1 chk("flush_start_stall", stallRequest, 32'd0);
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      #1 chk("flush_start_no_accept", busy, 32'd0);
      chk("flush_start_result", result, last_res);
      repeat (3) @(negedge clock);

      // 4-bit-per-cycle divider: done in cycle 10
      run4(MD_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 10);
      run4(MD_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 10);
      @(negedge clock);
      op4 = MD_DIVU; a4 = 32'd1000; b4 = 32'd7; start4 = 1'b1;
      repeat (5) @(negedge clock);
      reset4 = 1'b1;
      @(negedge clock);
      reset4 = 1'b0; start4 = 1'b0;
      #1 chk("reset4_result", result4, 32'd0);
      chk("reset4_idle", busy4, 32'd0);
      repeat (15) @(negedge clock);

      chk("pending", q.size(), 32'd0);
      chk("pending4", q4.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
